// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and the framebuffer geometry for the
// scanout path; the framebuffer is 320x240 and shown with 2x pixel doubling.
package vga_pkg;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_FP     = 10'd16;
    localparam logic [9:0] H_SYNC   = 10'd96;
    localparam logic [9:0] H_BP     = 10'd48;
    localparam logic [9:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_FP     = 10'd10;
    localparam logic [9:0] V_SYNC   = 10'd2;
    localparam logic [9:0] V_BP     = 10'd33;
    localparam logic [9:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = H_TOTAL - 10'd1;
    localparam logic [9:0] V_LAST       = V_TOTAL - 10'd1;
    localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic [16:0] FB_W     = 17'd320;
    localparam logic [16:0] FB_H     = 17'd240;
    localparam logic [16:0] FB_DEPTH = 17'd76800;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Beam position counters with undelayed syncs, active flag and frame strobes;
// everything advances only on the pixel enable.
module vga_timing_gen
    import vga_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pix_ce,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       vblank,
    output logic       line_end,
    output logic       frame_end,
    output logic       vblank_start
);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (i_pix_ce) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Strobes are qualified with the enable so they mark the advancing edge.
    assign line_end     = i_pix_ce && (h_cnt == H_LAST);
    assign frame_end    = line_end && (v_cnt == V_LAST);
    assign vblank_start = line_end && (v_cnt == V_ACTIVE - 10'd1);

    assign hsync  = !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
    assign vsync  = !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
    assign active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
    assign vblank = (v_cnt >= V_ACTIVE);

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer reader: doubled-pixel address generation, two-stage pixel
// pipeline aligned with sync, and tear-free double-buffer selection.
module fb_scanout
    import vga_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_ce,
    output logic [16:0] o_fb_addr,
    output logic        o_fb_re,
    output logic        o_fb_sel,
    input  logic [11:0] i_fb_pixel,
    input  logic        i_swap_req,
    output logic        o_swap_ack,
    output logic        o_vblank,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic [3:0]  o_r,
    output logic [3:0]  o_g,
    output logic [3:0]  o_b
);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        hsync_raw;
    logic        vsync_raw;
    logic        active_raw;
    logic        vblank_raw;
    logic        line_end;
    logic        frame_end;
    logic        vblank_start;

    logic [16:0] row_base;
    logic        hsync_d;
    logic        vsync_d;
    logic        vblank_d;
    logic        pending;
    rgb444_t     pix;

    vga_timing_gen u_timing (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pix_ce     (i_pix_ce),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt),
        .hsync        (hsync_raw),
        .vsync        (vsync_raw),
        .active       (active_raw),
        .vblank       (vblank_raw),
        .line_end     (line_end),
        .frame_end    (frame_end),
        .vblank_start (vblank_start)
    );

    // Each source row is shown on two screen lines, so the base moves after odd lines.
    always_ff @(posedge i_clk) begin
        if (i_rst || frame_end) begin
            row_base <= '0;
        end else if (line_end && v_cnt[0] && (v_cnt < V_ACTIVE)) begin
            row_base <= row_base + FB_W;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_fb_addr <= '0;
            o_fb_re   <= 1'b0;
            hsync_d   <= 1'b1;
            vsync_d   <= 1'b1;
            vblank_d  <= 1'b0;
        end else if (i_pix_ce) begin
            o_fb_addr <= row_base + {8'd0, h_cnt[9:1]};
            o_fb_re   <= active_raw;
            hsync_d   <= hsync_raw;
            vsync_d   <= vsync_raw;
            vblank_d  <= vblank_raw;
        end
    end

    // BRAM data has settled by the next enable, so no extra stage is needed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pix      <= '0;
            o_hsync  <= 1'b1;
            o_vsync  <= 1'b1;
            o_vblank <= 1'b0;
        end else if (i_pix_ce) begin
            pix      <= o_fb_re ? rgb444_t'(i_fb_pixel) : '0;
            o_hsync  <= hsync_d;
            o_vsync  <= vsync_d;
            o_vblank <= vblank_d;
        end
    end

    assign o_r = pix.r;
    assign o_g = pix.g;
    assign o_b = pix.b;

    // Swap handshake: i_swap_req is a one-cycle pulse that is latched into
    // pending (repeat pulses merge); at the first vblank edge with a request
    // outstanding, o_fb_sel flips and o_swap_ack pulses for exactly one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending    <= 1'b0;
            o_fb_sel   <= 1'b0;
            o_swap_ack <= 1'b0;
        end else begin
            o_swap_ack <= 1'b0;
            if (vblank_start && (pending || i_swap_req)) begin
                o_fb_sel   <= ~o_fb_sel;
                o_swap_ack <= 1'b1;
                pending    <= 1'b0;
            end else if (i_swap_req) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: beam model, framebuffer model returning
// addr[11:0], scoreboard of delayed output words, and swap/reset scenarios.
module tb_fb_scanout;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_pix_ce = 1'b0;
    logic        i_swap_req = 1'b0;
    logic [11:0] i_fb_pixel = 12'h000;
    logic [16:0] o_fb_addr;
    logic        o_fb_re;
    logic        o_fb_sel;
    logic        o_swap_ack;
    logic        o_vblank;
    logic        o_hsync;
    logic        o_vsync;
    logic [3:0]  o_r;
    logic [3:0]  o_g;
    logic [3:0]  o_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [14:0] exp_q[$];
    logic [14:0] last_exp = '0;
    int mh = 0, mv = 0, ph = 0, pv = 0, n_ce = 0;
    int hs_falls = 0, vs_low = 0, vb_high = 0;
    logic hs_prev = 1'b1;
    int ack_cnt = 0;
    int ack_base = 0;

    int tbl_h[7] = '{0, 1, 0, 1, 2, 639, 5};
    int tbl_v[7] = '{0, 0, 1, 1, 0, 479, 3};
    int tbl_a[7] = '{0, 0, 0, 0, 1, 76799, 322};

    fb_scanout dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_pix_ce   (i_pix_ce),
        .o_fb_addr  (o_fb_addr),
        .o_fb_re    (o_fb_re),
        .o_fb_sel   (o_fb_sel),
        .i_fb_pixel (i_fb_pixel),
        .i_swap_req (i_swap_req),
        .o_swap_ack (o_swap_ack),
        .o_vblank   (o_vblank),
        .o_hsync    (o_hsync),
        .o_vsync    (o_vsync),
        .o_r        (o_r),
        .o_g        (o_g),
        .o_b        (o_b)
    );

    // Clock and framebuffer read port: one-cycle latency, all-ones when not enabled.
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        i_fb_pixel <= o_fb_re ? o_fb_addr[11:0] : 12'hFFF;
    end

    always @(negedge i_clk) begin
        if (o_swap_ack) ack_cnt = ack_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (line %0d h %0d)", tag, got, exp, mv, mh);
        end
    endtask

    function automatic int ref_addr(input int h, input int v);
        return (v / 2) * 320 + h / 2;
    endfunction

    function automatic logic ref_active(input int h, input int v);
        return (h < 640) && (v < 480);
    endfunction

    function automatic logic [14:0] exp_word(input int h, input int v);
        logic       hs, vs, vb;
        logic [11:0] rgb;
        int a;
        a   = ref_addr(h, v);
        hs  = !((h >= 656) && (h < 752));
        vs  = !((v == 490) || (v == 491));
        vb  = (v >= 480);
        rgb = ref_active(h, v) ? a[11:0] : 12'h000;
        return {hs, vs, vb, rgb};
    endfunction

    function automatic logic in_window(input int v);
        return (v <= 2) || ((v >= 478) && (v <= 481)) || (v == 489) || (v == 492) || (v == 524);
    endfunction

    // One pixel enable after idle cycles; the model advances and outputs are checked.
    task automatic ce_step(input int idle, input logic req, input logic chk);
        logic [14:0] obs;
        for (int i = 0; i < idle; i++) begin
            @(negedge i_clk);
            i_pix_ce   = 1'b0;
            i_swap_req = 1'b0;
        end
        @(negedge i_clk);
        i_pix_ce   = 1'b1;
        i_swap_req = req;
        @(posedge i_clk);
        #1;
        ph = mh;
        pv = mv;
        n_ce++;
        if (mh == 799) begin
            mh = 0;
            mv = (mv == 524) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
        exp_q.push_back(exp_word(ph, pv));
        obs = {o_hsync, o_vsync, o_vblank, o_r, o_g, o_b};
        if (exp_q.size() > 1) begin
            last_exp = exp_q.pop_front();
            if (chk) check_eq("pix_out", obs, last_exp);
        end
        if (chk) begin
            check_eq("fb_re", o_fb_re, ref_active(ph, pv));
            if (ref_active(ph, pv)) check_eq("fb_addr", o_fb_addr, ref_addr(ph, pv));
            for (int t = 0; t < 7; t++)
                if (tbl_h[t] == ph && tbl_v[t] == pv) check_eq("addr_tbl", o_fb_addr, tbl_a[t]);
        end
        if (n_ce <= 420002) begin
            if (!o_hsync && hs_prev) hs_falls++;
            hs_prev = o_hsync;
            if (!o_vsync) vs_low++;
            if (o_vblank) vb_high++;
        end
    endtask

    task automatic run_until(input int tv, input int th, input logic slow);
        int guard;
        guard = 0;
        while (!(mv == tv && mh == th)) begin
            if (slow) ce_step(3, 1'b0, 1'b1);
            else if (in_window(mv)) ce_step(3, 1'b0, 1'b1);
            else ce_step(0, 1'b0, 1'b0);
            guard++;
            if (guard > 420000) begin
                check_eq("run_timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst      = 1'b1;
        i_pix_ce   = 1'b1;
        i_swap_req = 1'b0;
        @(posedge i_clk);
        #1;
        check_eq("rst_addr", o_fb_addr, 0);
        check_eq("rst_out", {o_hsync, o_vsync, o_vblank, o_fb_re, o_fb_sel, o_swap_ack, o_r, o_g, o_b},
                 {3'b110, 3'b000, 12'h000});
        @(negedge i_clk);
        i_rst    = 1'b0;
        i_pix_ce = 1'b0;
        mh = 0; mv = 0; n_ce = 0;
        exp_q.delete();
        hs_prev = 1'b1; hs_falls = 0; vs_low = 0; vb_high = 0;
        ack_base = ack_cnt;
    endtask

    initial begin
        do_reset();

        // Slow cadence through the first lines, then freeze mid-line.
        run_until(2, 40, 1'b1);
        for (int i = 0; i < 50; i++) begin
            @(negedge i_clk);
            i_pix_ce = 1'b0;
        end
        #1;
        check_eq("frz_addr", o_fb_addr, ref_addr(ph, pv));
        check_eq("frz_out", {o_hsync, o_vsync, o_vblank, o_r, o_g, o_b}, last_exp);
        run_until(3, 100, 1'b1);

        // Pending swap, then reset mid-frame must drop it.
        ce_step(3, 1'b1, 1'b1);
        run_until(4, 0, 1'b1);
        ce_step(3, 1'b1, 1'b1);
        run_until(6, 0, 1'b1);
        check_eq("sel_hold", o_fb_sel, 0);
        do_reset();

        // Full frame from reset with no requests.
        while (n_ce < 420002) begin
            if (in_window(mv)) ce_step(3, 1'b0, 1'b1);
            else ce_step(0, 1'b0, 1'b0);
        end
        check_eq("hsync_pulses", hs_falls, 525);
        check_eq("vsync_ces", vs_low, 1600);
        check_eq("vblank_ces", vb_high, 36000);
        check_eq("no_swap_sel", o_fb_sel, 0);
        check_eq("no_swap_ack", ack_cnt - ack_base, 0);

        // Three requests in one frame give a single toggle at vblank start.
        run_until(100, 0, 1'b0);
        ce_step(0, 1'b1, 1'b0);
        run_until(200, 0, 1'b0);
        ce_step(0, 1'b1, 1'b0);
        run_until(300, 0, 1'b0);
        ce_step(0, 1'b1, 1'b0);
        run_until(479, 799, 1'b0);
        check_eq("sel_before", o_fb_sel, 0);
        check_eq("ack_before", ack_cnt - ack_base, 0);
        ce_step(3, 1'b0, 1'b1);
        check_eq("sel_toggle", o_fb_sel, 1);
        check_eq("ack_pulse", o_swap_ack, 1);
        run_until(480, 10, 1'b0);
        check_eq("ack_count1", ack_cnt - ack_base, 1);
        check_eq("sel_after", o_fb_sel, 1);

        // Request landing on the exact vblank-start cycle toggles this frame.
        run_until(479, 799, 1'b0);
        check_eq("sel_pre_edge", o_fb_sel, 1);
        ce_step(3, 1'b1, 1'b1);
        check_eq("sel_edge_req", o_fb_sel, 0);
        check_eq("ack_edge_req", o_swap_ack, 1);
        run_until(480, 10, 1'b0);
        check_eq("ack_count2", ack_cnt - ack_base, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
